// File: rtl/icache_assoc.sv
// icache_assoc: set-associative instruction cache with LRU replacement, multi-word block fill and whole-cache flush
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2,
    parameter int CPUID = 0
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        flush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);
    localparam int IB = $clog2(SETS);
    localparam int WB = $clog2(WORDS);
    localparam int OW = WB > 0 ? WB : 1;
    localparam int AW = WAYS > 1 ? $clog2(WAYS) : 1;
    localparam int TW = 30 - WB - IB;
    localparam int unused_cpuid = CPUID;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [TW-1:0]   ltag_q;
    logic [IB-1:0]   lidx_q;
    logic [AW-1:0]   vic_q;
    logic            valid_q [SETS][WAYS];
    logic [AW-1:0]   age_q   [SETS][WAYS];
    logic [TW-1:0]   tags_q  [SETS][WAYS];
    logic [31:0]     data_q  [SETS][WAYS][WORDS];

    logic [TW-1:0]   tag;
    logic [IB-1:0]   idx;
    logic [OW-1:0]   woff;
    logic            match, hit, last, accept, done, mru_en;
    logic [AW-1:0]   hway, victim, mru_way, mru_old;
    logic [IB-1:0]   mru_set;
    logic            unused_bits;

    assign tag         = imemaddr[31 -: TW];
    assign idx         = imemaddr[2+WB +: IB];
    assign woff        = WB > 0 ? imemaddr[2 +: OW] : '0;
    assign unused_bits = ^imemaddr[1:0];

    always_comb begin
        match  = 1'b0;
        hway   = '0;
        victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && tags_q[idx][w] == tag) begin
                match = 1'b1;
                hway  = AW'(w);
            end
            if (age_q[idx][w] == AW'(WAYS-1)) victim = AW'(w);
        end
        for (int w = WAYS-1; w >= 0; w--)
            if (!valid_q[idx][w]) victim = AW'(w);
    end

    assign hit      = imemREN && state_q == IDLE && match;
    assign ihit     = hit;
    assign imemload = hit ? data_q[idx][hway][woff] : '0;
    assign last     = WB == 0 || cnt_q == OW'(WORDS-1);
    assign accept   = state_q == FILL && !iwait;
    assign done     = accept && last;
    assign iREN     = state_q == FILL;
    assign iaddr    = iREN ? ({ltag_q, lidx_q, {(WB+2){1'b0}}} | {{(30-OW){1'b0}}, cnt_q, 2'b00}) : '0;

    // A freshly filled invalid way counts as oldest, so ages settle into a permutation after flush/reset
    assign mru_en  = hit || done;
    assign mru_set = hit ? idx : lidx_q;
    assign mru_way = hit ? hway : vic_q;
    assign mru_old = hit ? age_q[idx][hway]
                   : valid_q[lidx_q][vic_q] ? age_q[lidx_q][vic_q] : AW'(WAYS-1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                if (flush) state_d = FLUSH;
                else if (imemREN && !match) begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            end
            FILL: begin
                pend_d = pend_q || flush;
                if (!iwait) cnt_d = last ? '0 : cnt_q + 1'b1;
                if (done) begin
                    state_d = (pend_q || flush) ? FLUSH : IDLE;
                    pend_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            ltag_q  <= '0;
            lidx_q  <= '0;
            vic_q   <= '0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w] <= 1'b0;
                    age_q[s][w]   <= '0;
                end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            if (state_q == IDLE && state_d == FILL) begin
                ltag_q <= tag;
                lidx_q <= idx;
                vic_q  <= victim;
            end
            if (state_q == FLUSH) begin
                for (int s = 0; s < SETS; s++)
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[s][w] <= 1'b0;
                        age_q[s][w]   <= '0;
                    end
            end else if (mru_en) begin
                for (int w = 0; w < WAYS; w++)
                    age_q[mru_set][w] <= AW'(w) == mru_way ? '0
                                       : age_q[mru_set][w] < mru_old ? age_q[mru_set][w] + 1'b1
                                       : age_q[mru_set][w];
                if (done) valid_q[lidx_q][vic_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            data_q[lidx_q][vic_q][cnt_q] <= iload;
            if (last) tags_q[lidx_q][vic_q] <= ltag_q;
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: scoreboard bench for icache_assoc (2-way/2-word and direct-mapped/1-word instances)
module tb_icache_assoc;
    logic clk = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    logic        a_ren, a_flush, a_ihit, a_iREN, a_iwait;
    logic [31:0] a_addr, a_load, a_iaddr, a_iload;
    logic        b_ren, b_flush, b_ihit, b_iREN, b_iwait;
    logic [31:0] b_addr, b_load, b_iaddr, b_iload;
    logic [3:0]  a_mw = 4'd0, b_mw = 4'd0, a_wc, b_wc;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_a[$], exp_b[$], acc_a[$], acc_b[$];

    function automatic logic [31:0] memw(input logic [31:0] a);
        return a ^ 32'hC0DE_5A5A;
    endfunction

    assign a_iwait = a_iREN && (a_wc < a_mw);
    assign b_iwait = b_iREN && (b_wc < b_mw);
    assign a_iload = memw(a_iaddr);
    assign b_iload = memw(b_iaddr);

    always @(posedge clk or negedge nRST)
        if (!nRST) a_wc <= 4'd0;
        else if (a_iREN) a_wc <= a_iwait ? a_wc + 4'd1 : 4'd0;

    always @(posedge clk or negedge nRST)
        if (!nRST) b_wc <= 4'd0;
        else if (b_iREN) b_wc <= b_iwait ? b_wc + 4'd1 : 4'd0;

    icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2), .CPUID(0)) u_a (
        .clk(clk), .nRST(nRST), .imemREN(a_ren), .imemaddr(a_addr), .flush(a_flush),
        .ihit(a_ihit), .imemload(a_load), .iREN(a_iREN), .iaddr(a_iaddr),
        .iwait(a_iwait), .iload(a_iload));

    icache_assoc #(.SETS(16), .WAYS(1), .WORDS(1), .CPUID(1)) u_b (
        .clk(clk), .nRST(nRST), .imemREN(b_ren), .imemaddr(b_addr), .flush(b_flush),
        .ihit(b_ihit), .imemload(b_load), .iREN(b_iREN), .iaddr(b_iaddr),
        .iwait(b_iwait), .iload(b_iload));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (a_iREN && !a_iwait) acc_a.push_back(a_iaddr);
        if (b_iREN && !b_iwait) acc_b.push_back(b_iaddr);
        if (a_ihit) begin
            if (exp_a.size() == 0) check("a_unexpected_hit", 32'(a_ihit), 32'd0);
            else check("a_imemload", a_load, exp_a.pop_front());
        end
        if (b_ihit) begin
            if (exp_b.size() == 0) check("b_unexpected_hit", 32'(b_ihit), 32'd0);
            else check("b_imemload", b_load, exp_b.pop_front());
        end
    end

    task automatic fetch(input bit b, input logic [31:0] addr, input int flush_cyc,
                         output int lat, output int ren);
        logic hit_s = 1'b0;
        logic zero_ok = 1'b1;
        lat = 0;
        ren = 0;
        if (b) exp_b.push_back(memw({addr[31:2], 2'b00}));
        else   exp_a.push_back(memw({addr[31:2], 2'b00}));
        @(posedge clk); #1;
        if (b) begin b_ren = 1'b1; b_addr = addr; end
        else   begin a_ren = 1'b1; a_addr = addr; end
        for (int c = 0; c < 60; c++) begin
            a_flush = (!b && c == flush_cyc);
            @(negedge clk);
            hit_s = b ? b_ihit : a_ihit;
            if (b ? b_iREN : a_iREN) ren++;
            if (!hit_s && (b ? b_load : a_load) != 32'd0) zero_ok = 1'b0;
            if (hit_s) break;
            lat++;
            @(posedge clk); #1;
        end
        check("hit_seen", 32'(hit_s), 32'd1);
        check("load_zero_on_miss", 32'(zero_ok), 32'd1);
        @(posedge clk); #1;
        a_ren = 1'b0;
        b_ren = 1'b0;
        a_flush = 1'b0;
    endtask

    task automatic fx(input bit b, input logic [31:0] addr, input int flush_cyc,
                      input int exp_lat, input int exp_ren, input string nm);
        int lat, ren;
        fetch(b, addr, flush_cyc, lat, ren);
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        check({nm, "_iren_cycles"}, 32'(ren), 32'(exp_ren));
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        nRST = 1'b0;
        @(posedge clk); #1;
        nRST = 1'b1;
        acc_a.delete();
        acc_b.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        a_ren = 1'b0; a_addr = '0; a_flush = 1'b0;
        b_ren = 1'b0; b_addr = '0; b_flush = 1'b0;
        #2;
        check("rst_ihit", 32'(a_ihit), 32'd0);
        check("rst_imemload", a_load, 32'd0);
        check("rst_iREN", 32'(a_iREN), 32'd0);
        check("rst_iaddr", a_iaddr, 32'd0);
        check("rst_b_iREN", 32'(b_iREN), 32'd0);
        repeat (2) @(posedge clk);
        #1 nRST = 1'b1;

        a_mw = 4'd1;
        fx(1'b0, 32'h40, -1, 5, 4, "cold_0x40");
        check("cold_acc_n", 32'(acc_a.size()), 32'd2);
        check("cold_acc0", acc_a[0], 32'h40);
        check("cold_acc1", acc_a[1], 32'h44);
        fx(1'b0, 32'h44, -1, 0, 0, "hit_0x44");

        reset_dut();
        a_mw = 4'd0;
        fx(1'b0, 32'h000, -1, 3, 2, "lru_fill_000");
        fx(1'b0, 32'h100, -1, 3, 2, "lru_fill_100");
        fx(1'b0, 32'h000, -1, 0, 0, "lru_hit_000");
        fx(1'b0, 32'h200, -1, 3, 2, "lru_fill_200");
        fx(1'b0, 32'h000, -1, 0, 0, "lru_hit_000_again");
        fx(1'b0, 32'h100, -1, 3, 2, "lru_100_evicted");

        reset_dut();
        @(posedge clk); #1;
        a_ren = 1'b1; a_addr = 32'h40;
        @(posedge clk); #1;
        a_ren = 1'b0; a_addr = 32'h80;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!a_iREN) break;
        end
        check("drop_fill_done", 32'(a_iREN), 32'd0);
        check("drop_acc_n", 32'(acc_a.size()), 32'd2);
        check("drop_acc0", acc_a[0], 32'h40);
        check("drop_acc1", acc_a[1], 32'h44);
        fx(1'b0, 32'h40, -1, 0, 0, "drop_hit_0x40");
        fx(1'b0, 32'h80, -1, 3, 2, "drop_miss_0x80");

        reset_dut();
        a_mw = 4'd1;
        fx(1'b0, 32'h40, 1, 11, 8, "flush_in_fill");
        check("flush_acc_n", 32'(acc_a.size()), 32'd4);
        fx(1'b0, 32'h44, -1, 0, 0, "flush_refilled_hit");

        reset_dut();
        @(posedge clk); #1;
        a_ren = 1'b1; a_addr = 32'h40;
        @(posedge clk); #1;
        check("prerst_iREN", 32'(a_iREN), 32'd1);
        check("prerst_iwait", 32'(a_iwait), 32'd1);
        nRST = 1'b0;
        #1;
        check("midrst_iREN", 32'(a_iREN), 32'd0);
        check("midrst_iaddr", a_iaddr, 32'd0);
        a_ren = 1'b0;
        @(posedge clk); #1;
        nRST = 1'b1;
        acc_a.delete();
        fx(1'b0, 32'h40, -1, 5, 4, "after_rst_miss");

        b_mw = 4'd0;
        fx(1'b1, 32'h0, -1, 2, 1, "dm_fill_0");
        fx(1'b1, 32'h40, -1, 2, 1, "dm_fill_40");
        fx(1'b1, 32'h0, -1, 2, 1, "dm_refetch_0");
        fx(1'b1, 32'h0, -1, 0, 0, "dm_hit_0");
        check("dm_acc0", acc_b[0], 32'h0);
        check("dm_acc1", acc_b[1], 32'h40);

        check("scoreboard_a_empty", 32'(exp_a.size()), 32'd0);
        check("scoreboard_b_empty", 32'(exp_b.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/icache_assoc.md
# icache_assoc

Parametrised set-associative instruction cache for the per-core fetch path. It sits between the datapath fetch port and the memory controller's instruction channel, in the same position as the direct-mapped single-word icache it replaces. It adds configurable sets, ways and words per block, LRU replacement, sequential multi-word block fills and a whole-cache flush. Hits are combinational; misses run a fill state machine against the controller's iREN/iwait handshake.

## Interface
- SETS, 8: number of sets; power of 2, ≥2.
- WAYS, 2: associativity; one of 1, 2, 4.
- WORDS, 2: 32-bit words per block; power of 2, ≥1.
- CPUID, 0: core index; documentation only, ports are per-core.
- clk  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- imemREN  in  1  datapath fetch request.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- flush  in  1  level request to invalidate every line.
- ihit  out  1  imemload valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  memory read request.
- iaddr  out  32  memory word address.
- iwait  in  1  memory not ready; iload valid when iREN && !iwait.
- iload  in  32  memory read data.

## Operation
- Address split: [1:0] byte, then log2(WORDS) word offset, then log2(SETS) index. The remaining upper bits form the tag.
- Per line state: valid, tag, WORDS data words. Per set state: an age of log2(WAYS) bits for each way, used as the LRU. WAYS=1 has no age state.
- Lookup: hit when imemREN, state IDLE, and any way in the indexed set has valid and a matching tag. On a hit:
  - ihit=1 and imemload = that way's word at the word offset, in the same cycle.
  - The hit way becomes MRU: its age is set to 0, and ways younger than its old age increment.
- When ihit=0, imemload=0.
- FSM states:
  - IDLE: on imemREN && !hit && !flush, latch tag, index and victim way, set the word counter to 0, and go to FILL.
  - FILL: iREN=1 and iaddr = {latched tag, index, counter, 2'b00}. On !iwait, write iload into the victim way at the counter position and increment the counter.
    - On the last word: write valid=1 and the tag, make the victim MRU, and go to IDLE.
    - imemREN and imemaddr are ignored during FILL. The fill is never aborted.
  - FLUSH: clear every valid bit and all ages in one cycle, then go to IDLE.
- Flush priority:
  - flush sampled in IDLE goes to FLUSH. It takes priority over starting a miss.
  - flush sampled in FILL is remembered in a pending bit. FILL then exits to FLUSH instead of IDLE.
  - ihit=0 while in FLUSH.
- Victim choice: the lowest-numbered invalid way; otherwise the way with age WAYS-1.

## Timing
- Reset (asynchronous) values:
  - State IDLE, all valid bits 0, ages 0, counter 0, pending flush 0.
  - ihit=0, imemload=0, iREN=0, iaddr=0.
- Hit latency: 0 cycles (combinational from imemaddr).
- Miss sequence:
  - Miss detected in cycle 0; iREN rises in cycle 1.
  - Each word takes 1 + (cycles with iwait=1).
  - State returns to IDLE the cycle after the last word is accepted; ihit=1 in that cycle if the address is unchanged.
  - With a 1-cycle memory: miss penalty WORDS+1 cycles.
- iaddr holds steady while iwait=1 and advances only on acceptance.
- iREN deasserts the cycle after the last accepted word.
- Reset asserted mid-fill: the partial line is discarded (valid stays 0) and iREN drops immediately.
- Counter wrap: a counter of log2(WORDS) bits wraps to 0 on the last word. With WORDS=1 the counter is absent.

## Test plan
- Cold miss, SETS=8, WAYS=2, WORDS=2, memory iwait=1 for 1 cycle per word: fetch 0x00000040.
  - Required: iaddr 0x40 then 0x44, iREN high 4 cycles, ihit=1 on cycle 5 with imemload = word at 0x40.
  - Then 0x44 hits in 0 cycles.
- 2-way LRU: fill 0x000, 0x100, 0x200 (same set), hitting 0x000 between the 0x100 and 0x200 fills.
  - Required: 0x200 evicts the 0x100 line; 0x000 still hits; 0x100 misses.
- imemREN dropped and imemaddr changed to 0x80 mid-fill of 0x40.
  - Required: fill of 0x40/0x44 completes; 0x40 hits afterwards.
- flush pulsed during FILL.
  - Required: fill completes, one FLUSH cycle with ihit=0, then the just-filled address misses.
- nRST pulsed low while iwait=1 in FILL.
  - Required: iREN=0 immediately, no line valid, the next fetch misses.
- WAYS=1, WORDS=1, SETS=16: fetch 0x0, then 0x40 (same index).
  - Required: the second fetch evicts the first; refetch of 0x0 misses.
